// File: rtl/u409_cia_cycle_if.sv
// Bus-side signal bundle for the CIA cycle sequencer.
// The master is the bus/CLK7 side; the slave is the sequencer itself.
interface u409_cia_cycle_if;
  logic CIA_SPACE;
  logic RnW;
  logic CLKCIA;
  logic CIA_ENABLE;
  logic DATA_LATCH;
  logic DRIVE_WR;
  logic TACK;
  logic TEA;
  logic BUSY;

  modport master (
    output CIA_SPACE, RnW, CLKCIA, CIA_ENABLE,
    input  DATA_LATCH, DRIVE_WR, TACK, TEA, BUSY
  );

  modport slave (
    input  CIA_SPACE, RnW, CLKCIA, CIA_ENABLE,
    output DATA_LATCH, DRIVE_WR, TACK, TEA, BUSY
  );
endinterface

// File: rtl/u409_cia_cycle.sv
// CIA bus-cycle sequencer: aligns a CLK40 bus cycle to the asynchronous CIA E clock,
// producing the read-data latch strobe, write-driver enable, acknowledge and timeout error.
module u409_cia_cycle #(
  parameter int unsigned TIMEOUT = 200
) (
  input  logic            CLK40,
  input  logic            RESET,
  u409_cia_cycle_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SEL,
    WAIT_RISE,
    WAIT_FALL,
    ACK,
    RECOVER
  } state_e;

  localparam logic [7:0] LastCount = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [1:0] e_sync_q, en_sync_q;
  logic       e_hist_q, en_hist_q;
  logic       latch_q, latch_d;
  logic       tack_q, tack_d;
  logic       tea_q, tea_d;
  logic       busy_q;

  logic e_rise, e_fall, en_seen;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK40 or posedge RESET) begin
    if (RESET) begin
      e_sync_q  <= '0;
      en_sync_q <= '0;
      e_hist_q  <= 1'b0;
      en_hist_q <= 1'b0;
    end else begin
      e_sync_q  <= {e_sync_q[0], bus.CLKCIA};
      en_sync_q <= {en_sync_q[0], bus.CIA_ENABLE};
      e_hist_q  <= e_sync_q[1];
      en_hist_q <= en_sync_q[1];
    end
  end

  assign e_rise  =  e_sync_q[1] & ~e_hist_q;
  assign e_fall  = ~e_sync_q[1] &  e_hist_q;
  // Chip-select must be seen on two consecutive samples, rejecting a one-sample glitch.
  assign en_seen =  en_sync_q[1] & en_hist_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    count_d = count_q;
    latch_d = 1'b0;
    tack_d  = 1'b0;
    tea_d   = 1'b0;

    case (state_q)
      IDLE: begin
        count_d = '0;
        if (bus.CIA_SPACE) state_d = WAIT_SEL;
      end

      WAIT_SEL, WAIT_RISE, WAIT_FALL: begin
        if (count_q != 8'hFF) count_d = count_q + 8'd1;
        // Priority: abort, then a completing E fall (beats a coincident timeout), then timeout.
        if (!bus.CIA_SPACE) begin
          state_d = IDLE;
        end else if (state_q == WAIT_FALL && e_fall) begin
          latch_d = bus.RnW;
          state_d = ACK;
        end else if (count_q == LastCount) begin
          tea_d   = 1'b1;
          state_d = RECOVER;
        end else if (state_q == WAIT_SEL && en_seen) begin
          state_d = WAIT_RISE;
        end else if (state_q == WAIT_RISE && e_rise) begin
          state_d = WAIT_FALL;
        end
      end

      ACK: begin
        tack_d  = 1'b1;
        state_d = RECOVER;
      end

      RECOVER: begin
        if (!bus.CIA_SPACE) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK40 or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      count_q <= '0;
      latch_q <= 1'b0;
      tack_q  <= 1'b0;
      tea_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      latch_q <= latch_d;
      tack_q  <= tack_d;
      tea_q   <= tea_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.DATA_LATCH = latch_q;
  assign bus.TACK       = tack_q;
  assign bus.TEA        = tea_q;
  assign bus.BUSY       = busy_q;
  // Combinational so the write drivers release in the very cycle CIA_SPACE drops.
  assign bus.DRIVE_WR   = bus.CIA_SPACE & ~bus.RnW &
                          (state_q inside {WAIT_SEL, WAIT_RISE, WAIT_FALL, ACK});

endmodule

// File: doc/u409_cia_cycle.md
U409_CIA_CYCLE -- requirements
Module: u409_cia_cycle

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- TIMEOUT, 200, CLK40 cycles from cycle start to forced bus error (legal 16..255).
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- CLK40  in  1  40MHz bus clock; sole clock of the block.
- RESET  in  1  asynchronous, active-high reset.
- CIA_SPACE  in  1  CLK40-synchronous CIA address decode, held high for the whole bus cycle.
- RnW  in  1  CLK40-synchronous direction; 1=read, 0=write; stable while CIA_SPACE high.
- CLKCIA  in  1  CIA clock (E), generated in the CLK7 domain; asynchronous to CLK40.
- CIA_ENABLE  in  1  CIA chip-select window, CLK7 domain; asynchronous to CLK40.
- DATA_LATCH  out  1  one-cycle strobe; capture CIA read data into the bus latch.
- DRIVE_WR  out  1  enable bus-to-CIA write data drivers.
- TACK  out  1  one-cycle transfer acknowledge to the bus.
- TEA  out  1  one-cycle transfer error (timeout) to the bus.
- BUSY  out  1  high whenever state is not IDLE.

Function
REQ-003 CLKCIA and CIA_ENABLE SHALL each pass through a two-flop synchronizer plus one history flop in CLK40.
REQ-004 E_RISE SHALL be synced CLKCIA high with history low; E_FALL SHALL be synced CLKCIA low with history high; each is one CLK40 cycle wide.
REQ-005 An E edge SHALL be visible as E_RISE/E_FALL on the third CLK40 rising edge after the CLKCIA transition (±1 cycle of sampling uncertainty).
REQ-006 The state machine SHALL have states IDLE, WAIT_SEL, WAIT_RISE, WAIT_FALL, ACK, RECOVER.
REQ-007 IDLE -> WAIT_SEL when CIA_SPACE=1; timeout counter cleared to 0 on that transition.
REQ-008 WAIT_SEL -> WAIT_RISE when synced CIA_ENABLE=1.
REQ-009 WAIT_RISE -> WAIT_FALL on E_RISE; an E_FALL seen in WAIT_RISE SHALL be ignored.
REQ-010 WAIT_FALL -> ACK on E_FALL; DATA_LATCH SHALL pulse for exactly the cycle E_FALL is seen in WAIT_FALL, and only when RnW=1.
REQ-011 ACK SHALL last one cycle with TACK=1, then go to RECOVER.
REQ-012 RECOVER -> IDLE when CIA_SPACE=0; a new cycle cannot start without CIA_SPACE first going low.
REQ-013 DRIVE_WR SHALL be 1 in WAIT_SEL, WAIT_RISE, WAIT_FALL and ACK when RnW=0, and 0 otherwise.
REQ-014 The timeout counter SHALL be 8 bits, increment each cycle in WAIT_SEL/WAIT_RISE/WAIT_FALL, and saturate rather than wrap.
REQ-015 When the counter equals TIMEOUT-1 in a waiting state, the block SHALL pulse TEA for one cycle, assert no TACK, and go to RECOVER.
REQ-016 If E_FALL and the timeout match occur in the same cycle in WAIT_FALL, the block SHALL complete normally (TACK), not TEA.
REQ-017 If CIA_SPACE drops in WAIT_SEL, WAIT_RISE or WAIT_FALL, the block SHALL go to IDLE the next cycle, with no TACK, TEA or DATA_LATCH, and DRIVE_WR SHALL drop that same cycle.
REQ-018 TACK and TEA SHALL never both be 1, and each SHALL fire at most once per CIA_SPACE assertion.
REQ-019 All outputs SHALL be registered, except DRIVE_WR, which SHALL be combinational from state, RnW and CIA_SPACE.

Reset
REQ-020 RESET=1 SHALL immediately force state IDLE, counter 0, all synchronizer and history flops 0, and DATA_LATCH, TACK, TEA, BUSY and DRIVE_WR all 0.
REQ-021 After RESET falls, no E_RISE/E_FALL SHALL be generated until the synced inputs have settled (first edge earliest 3 cycles later).
REQ-022 RESET asserted mid-cycle SHALL abort without TACK/TEA; with CIA_SPACE still high after release, a fresh cycle SHALL start in WAIT_SEL.

Verification
REQ-023 Read: CIA_SPACE=1, RnW=1, CLK7-generated E/CIA_ENABLE -> exactly one DATA_LATCH, TACK one cycle later, TEA=0, DRIVE_WR=0 throughout.
REQ-024 Write: RnW=0 -> DRIVE_WR=1 from WAIT_SEL entry through ACK, then 0; one TACK; no DATA_LATCH.
REQ-025 Timeout: CIA_SPACE=1 with CIA_ENABLE held 0, TIMEOUT=200 -> TEA pulse 200 cycles after the IDLE exit, no TACK, BUSY until CIA_SPACE=0.
REQ-026 Abort: drop CIA_SPACE in WAIT_FALL -> IDLE next cycle; TACK, TEA and DATA_LATCH stay 0.
REQ-027 Back-to-back: two CIA_SPACE assertions separated by one idle cycle -> exactly two TACKs, each aligned 1 cycle after its own E_FALL.
REQ-028 Reset: RESET pulse during WAIT_RISE -> all outputs 0 within the same cycle; after release with CIA_SPACE=1, the cycle restarts and completes with one TACK.
